// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : uart_pkg
//  Brief   : Shared UART types, defaults and the even-parity helper used by
//            both the transmitter and the receiver.
//  Rev     : 1.0  initial release
// ============================================================================
package uart_pkg;

    // Default number of sample ticks per bit period.
    localparam int OVERSAMPLE_DEFAULT = 16;

    // Receiver frame-tracking states.
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        PARITY     = 3'd3,
        STOP       = 3'd4,
        BREAK_WAIT = 3'd5
    } uart_state_t;

    // Even-parity bit for a data word. Zero-extension of narrower words
    // does not change the result, so one 32-bit form serves any width.
    function automatic logic even_parity(input logic [31:0] data);
        return ^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync2.sv
`default_nettype none
// ============================================================================
//  Module  : sync2
//  Brief   : Two-flop synchronizer for a single asynchronous input, with a
//            configurable reset value (defaults to 1 for idle-high lines).
//  Rev     : 1.0  initial release
// ============================================================================
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module  : uart_rx
//  Brief   : Oversampling UART receiver. Detects and confirms start bits,
//            shifts data in LSB first, optionally checks even parity, and
//            reports each frame with a one-cycle valid pulse and error flags.
//  Rev     : 1.0  initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic                 rx_pin,
    input  logic                 parity_enable,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_busy,
    output logic                 parity_error,
    output logic                 framing_error
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    // Start bit is re-checked half a bit after detection; every later bit
    // is sampled one full bit period after the previous sample.
    localparam logic [TICK_W-1:0] c_TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] c_TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  c_BIT_LAST  = BIT_W'(DATA_BITS - 1);

    uart_state_t            r_state;
    uart_state_t            w_state_next;
    logic [TICK_W-1:0]      r_tick_cnt;
    logic [BIT_W-1:0]       r_bit_cnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   r_rx_data;
    logic                   r_par_en;
    logic                   r_par_bit;
    logic                   r_rx_valid;
    logic                   r_par_err;
    logic                   r_frm_err;
    logic                   w_rx_s;

    logic                   w_tick_clr;
    logic                   w_tick_inc;
    logic                   w_bit_inc;
    logic                   w_shift_en;
    logic                   w_par_cap;
    logic                   w_confirm;
    logic                   w_frame_done;

    sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (rx_pin),
        .o_q   (w_rx_s)
    );

    // Frame state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and per-cycle datapath strobes.
    always_comb begin
        w_state_next = r_state;
        w_tick_clr   = 1'b0;
        w_tick_inc   = 1'b0;
        w_bit_inc    = 1'b0;
        w_shift_en   = 1'b0;
        w_par_cap    = 1'b0;
        w_confirm    = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (sample_tick && !w_rx_s) begin
                    w_state_next = START;
                    w_tick_clr   = 1'b1;
                end
            end
            START: begin
                if (sample_tick) begin
                    if (r_tick_cnt == c_TICK_MID) begin
                        if (w_rx_s) begin
                            w_state_next = IDLE;
                        end else begin
                            w_state_next = DATA;
                            w_tick_clr   = 1'b1;
                            w_confirm    = 1'b1;
                        end
                    end else begin
                        w_tick_inc = 1'b1;
                    end
                end
            end
            DATA: begin
                if (sample_tick) begin
                    if (r_tick_cnt == c_TICK_LAST) begin
                        w_tick_clr = 1'b1;
                        w_shift_en = 1'b1;
                        w_bit_inc  = 1'b1;
                        if (r_bit_cnt == c_BIT_LAST) begin
                            w_state_next = r_par_en ? PARITY : STOP;
                        end
                    end else begin
                        w_tick_inc = 1'b1;
                    end
                end
            end
            PARITY: begin
                if (sample_tick) begin
                    if (r_tick_cnt == c_TICK_LAST) begin
                        w_tick_clr   = 1'b1;
                        w_par_cap    = 1'b1;
                        w_state_next = STOP;
                    end else begin
                        w_tick_inc = 1'b1;
                    end
                end
            end
            STOP: begin
                if (sample_tick) begin
                    if (r_tick_cnt == c_TICK_LAST) begin
                        w_tick_clr   = 1'b1;
                        w_frame_done = 1'b1;
                        w_state_next = w_rx_s ? IDLE : BREAK_WAIT;
                    end else begin
                        w_tick_inc = 1'b1;
                    end
                end
            end
            BREAK_WAIT: begin
                // A held-low line produces one frame; wait for it to release.
                if (w_rx_s) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Counters, shift register, parity capture and frame result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
        end else begin
            r_rx_valid <= w_frame_done;

            if (w_tick_clr) begin
                r_tick_cnt <= '0;
            end else if (w_tick_inc) begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end

            // parity_enable is captured once per frame at start confirm.
            if (w_confirm) begin
                r_bit_cnt <= '0;
                r_par_en  <= parity_enable;
            end else if (w_bit_inc) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end

            // LSB arrives first, so shift in at the top and move right.
            if (w_shift_en) begin
                r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            end

            if (w_par_cap) begin
                r_par_bit <= w_rx_s;
            end

            if (w_frame_done) begin
                r_rx_data <= r_shift;
                r_par_err <= r_par_en & (even_parity(32'(r_shift)) ^ r_par_bit);
                r_frm_err <= ~w_rx_s;
            end
        end
    end

    assign rx_data       = r_rx_data;
    assign rx_valid      = r_rx_valid;
    assign parity_error  = r_par_err;
    assign framing_error = r_frm_err;
    // Busy covers the valid cycle so it drops one clock after the pulse.
    assign rx_busy       = (r_state != IDLE) || r_rx_valid;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module  : tb_uart_rx
//  Brief   : Self-checking bench for uart_rx. Serial frames are built from
//            the line protocol; expected bytes and flags come from a frame
//            queue computed from the same protocol rules.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sample_tick = 1'b0;
    logic       rx_pin = 1'b1;
    logic       parity_enable = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       parity_error;
    logic       framing_error;

    int n_assert = 0;
    int n_fail   = 0;

    // Line timing: tick every 6 clocks, or continuous ticks.
    bit tick_cont = 1'b0;
    int tick_div  = 0;
    int bit_clks  = 96;

    // Observed frames {data, parity_error, framing_error}.
    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];
    int  n_valid = 0;
    bit  prev_valid = 1'b0;
    bit  busy_at_valid = 1'b0;
    bit  busy_after_valid = 1'b1;
    bit  busy_seen = 1'b0;

    uart_rx #(
        .OVERSAMPLE (16),
        .DATA_BITS  (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_tick   (sample_tick),
        .rx_pin        (rx_pin),
        .parity_enable (parity_enable),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_busy       (rx_busy),
        .parity_error  (parity_error),
        .framing_error (framing_error)
    );

    always #5 clk = ~clk;

    // Sample-tick generator.
    initial begin
        forever begin
            @(negedge clk);
            if (tick_cont) begin
                sample_tick = 1'b1;
            end else begin
                sample_tick = (tick_div == 5);
                tick_div    = (tick_div == 5) ? 0 : tick_div + 1;
            end
        end
    end

    // Output monitor, sampled 1 ns after the active edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (prev_valid) busy_after_valid = rx_busy;
            if (rx_valid) begin
                got_q.push_back({rx_data, parity_error, framing_error});
                busy_at_valid = rx_busy;
                n_valid++;
            end
            prev_valid = rx_valid;
            if (rx_busy) busy_seen = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx_pin = b;
        repeat (bit_clks) @(negedge clk);
    endtask

    // One frame; flip inverts the correct even-parity bit. parity_enable is
    // scrambled after the first data bit, which must not affect this frame.
    task automatic send_frame(input logic [7:0] d, input bit par_on,
                              input bit flip, input bit stop_val);
        parity_enable = par_on;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            send_bit(d[i]);
            if (i == 0) parity_enable = 1'($urandom_range(0, 1));
        end
        if (par_on) send_bit((^d) ^ flip);
        send_bit(stop_val);
        exp_q.push_back({d, (par_on ? flip : 1'b0), ~stop_val});
    endtask

    task automatic idle_bits(input int n);
        rx_pin = 1'b1;
        repeat (n * bit_clks) @(negedge clk);
    endtask

    // Compare every queued expected frame against what the monitor saw.
    task automatic check_frames(input string tag);
        logic [9:0] g;
        logic [9:0] e;
        repeat (4) @(negedge clk);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_frame"}, g, e);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int v0;
        logic [7:0] rd;
        bit rp;
        bit rf;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_valid", rx_valid, 0);
        chk("rst_busy", rx_busy, 0);
        chk("rst_data", rx_data, 0);
        chk("rst_perr", parity_error, 0);
        chk("rst_ferr", framing_error, 0);
        reset = 1'b0;
        idle_bits(1);

        // 0x55 with correct even parity.
        send_frame(8'h55, 1'b1, 1'b0, 1'b1);
        check_frames("f55");
        chk("f55_busy_at_valid", busy_at_valid, 1);
        chk("f55_busy_after_valid", busy_after_valid, 0);
        idle_bits(1);
        chk("f55_data_held", rx_data, 8'h55);

        // 0xA3 with wrong parity, then without parity.
        send_frame(8'hA3, 1'b1, 1'b1, 1'b1);
        check_frames("fA3_bad");
        idle_bits(1);
        send_frame(8'hA3, 1'b0, 1'b0, 1'b1);
        check_frames("fA3_nopar");
        idle_bits(1);

        // Four-tick low glitch on an idle line.
        v0 = n_valid;
        busy_seen = 1'b0;
        rx_pin = 1'b0;
        repeat (24) @(negedge clk);
        rx_pin = 1'b1;
        idle_bits(3);
        chk("glitch_busy_seen", busy_seen, 1);
        chk("glitch_busy_end", rx_busy, 0);
        chk("glitch_no_valid", n_valid - v0, 0);

        // Stop bit low with the line held low for 30 bit times.
        v0 = n_valid;
        send_frame(8'h00, 1'b0, 1'b0, 1'b0);
        rx_pin = 1'b0;
        repeat (30 * bit_clks) @(negedge clk);
        chk("brk_busy_held", rx_busy, 1);
        idle_bits(2);
        chk("brk_busy_end", rx_busy, 0);
        chk("brk_one_valid", n_valid - v0, 1);
        check_frames("brk00");
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
        check_frames("fFF_after_brk");
        idle_bits(1);

        // Three back-to-back frames with no idle gap.
        send_frame(8'h01, 1'b0, 1'b0, 1'b1);
        send_frame(8'h80, 1'b0, 1'b0, 1'b1);
        send_frame(8'h7E, 1'b0, 1'b0, 1'b1);
        check_frames("b2b");
        idle_bits(1);

        // Reset in the middle of the data bits of 0x55.
        v0 = n_valid;
        parity_enable = 1'b0;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        repeat (bit_clks / 2) @(negedge clk);
        chk("mid_busy_before_rst", rx_busy, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", rx_busy, 0);
        chk("mid_rst_valid", rx_valid, 0);
        rx_pin = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        idle_bits(2);
        chk("mid_rst_no_valid", n_valid - v0, 0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        check_frames("f3C_after_rst");
        idle_bits(1);

        // Randomized frames, first at the divided tick, then continuous.
        for (int k = 0; k < 24; k++) begin
            if (k == 8) begin
                tick_cont = 1'b1;
                bit_clks  = 16;
                idle_bits(2);
            end
            rd = 8'($urandom_range(0, 255));
            rp = 1'($urandom_range(0, 1));
            rf = 1'($urandom_range(0, 1));
            send_frame(rd, rp, rf, 1'b1);
            if ($urandom_range(0, 1) == 1) idle_bits(1);
        end
        check_frames("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
